arf_rename: RTL and testbench
=============================

# arf_rename

Architectural register file plus rename table, sitting at the retire end of the ROB and the register-read end of dispatch. It consumes the ROB's retire stream (commits results into the ARF and releases rename mappings), records the ROB id of each newly dispatched destination, and answers source-operand lookups with either committed ARF data or the ROB id that will produce the value.

## Interface
Parameters:
- `N_ARF`, 32, architectural registers (x0 hardwired zero)
- `ROB_N_ENTRIES`, from global defs; sets `rob_id_t` width = clog2(`ROB_N_ENTRIES`)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_aL`  in  1  asynchronous active-low reset
- `retire`  in  1  ROB retires head this cycle
- `retire_rob_id`  in  rob_id_t  ROB id being retired
- `retire_arf_id`  in  arf_id_t (5)  destination architectural register
- `retire_reg_data`  in  reg_data_t (32)  committed value
- `dispatch_fire`  in  1  instruction dispatched this cycle (valid & ready already resolved upstream)
- `dispatch_dst_valid`  in  1  instruction writes a register
- `dispatch_dst_arf_id`  in  arf_id_t  destination register
- `dispatch_rob_id`  in  rob_id_t  ROB id allocated to it
- `src1_arf_id`, `src2_arf_id`  in  arf_id_t  source lookups
- `src1_renamed`, `src2_renamed`  out  1  value pending in ROB
- `src1_rob_id`, `src2_rob_id`  out  rob_id_t  producer ROB id (valid when renamed)
- `src1_reg_data`, `src2_reg_data`  out  reg_data_t  ARF/bypassed value (valid when not renamed)
- `flush`  in  1  pipeline flush (branch/load mispredict)

## Operation
- State: `arf[1..31]` 32-bit data; `rat[1..31]` = {valid, rob_id}. x0 has no storage.
- Retire (retire=1, arf_id≠0): `arf[arf_id] <= retire_reg_data`. If `rat[arf_id].valid` and `rat[arf_id].rob_id == retire_rob_id`, clear valid, unless rename below hits same register this cycle.
- Rename (dispatch_fire & dst_valid & dst≠0 & !flush): `rat[dst] <= {1, dispatch_rob_id}`. Rename beats retire-clear on the same register.
- Flush: all `rat` valid bits cleared at next edge; ARF untouched; same-cycle retire still writes ARF; same-cycle rename dropped.
- Lookup (per source, combinational, from pre-edge state):
  - arf_id=0 → renamed=0, data=0, rob_id=0.
  - rat valid and rob_id == retire_rob_id with retire=1 → bypass: renamed=0, data=retire_reg_data.
  - rat valid otherwise → renamed=1, rob_id=rat.rob_id, data=arf value (don't-care).
  - else → renamed=0, data=arf value.
- Lookups never see the same-cycle rename (an instruction's own dst does not alias its sources).
- Retire with arf_id=0 is a no-op.

## Timing
- Reset: all ARF = 0, all rat invalid; hence all outputs 0 during/after reset until state changes.
- Lookup latency 0 (combinational); ARF/RAT updates visible the cycle after the edge.
- Reset asserted mid-operation clears state immediately regardless of clk.
- One retire and one dispatch per cycle max; all combinations legal simultaneously.

## Structure
- `arf_id_t`, `rob_id_t`, `reg_data_t`, `rat_entry_t` {valid, rob_id} live in the shared global defs package.
- Sub-module `rat_entry`: one per register, flop with next-state priority reset > flush > rename > retire-clear > hold; exposes valid and rob_id.
- Lookup/bypass is a per-source mux; ARF built from standard-cell flops with write-enable.

## Test plan
- Reset, read x5 → renamed=0, data=0; retire x0 with 0xDEAD, read x0 → 0.
- Dispatch dst x3 rob 7; next cycle read x3 → renamed=1, rob_id=7; retire rob 7 x3 data 0x1234 → same cycle read x3 renamed=0 data 0x1234; next cycle rat invalid, data 0x1234.
- Rename x3→rob 7, then x3→rob 9; retire rob 7 x3 0x11 → arf=0x11 but x3 still renamed to 9.
- Same cycle: retire rob 4 x6 and dispatch x6→rob 12 → after edge x6 renamed=1 rob_id=12, arf[x6]=retire data.
- Rename x1,x2; assert flush together with retire of x1 data 0x55 and dispatch x8 → after edge nothing renamed, arf[x1]=0x55, x8 not renamed.
- Rename x10, drop rst_aL between edges → x10 immediately unrenamed, data 0.

Source files
------------

// File: rtl/arf_rename_pkg.sv
// arf_rename_pkg: shared register-file/rename types and the per-source lookup mux
package arf_rename_pkg;

    localparam int ROB_N_ENTRIES = 16;
    localparam int ARF_ID_W      = 5;
    localparam int REG_DATA_W    = 32;

    typedef logic [$clog2(ROB_N_ENTRIES)-1:0] rob_id_t;
    typedef logic [ARF_ID_W-1:0]              arf_id_t;
    typedef logic [REG_DATA_W-1:0]            reg_data_t;

    typedef struct packed {
        logic    valid;
        rob_id_t rob_id;
    } rat_entry_t;

    typedef struct packed {
        logic      renamed;
        rob_id_t   rob_id;
        reg_data_t data;
    } lookup_t;

    // A value retiring this cycle is forwarded instead of reporting a rename
    // that is about to disappear; x0 always reads as zero.
    function automatic lookup_t lookup_sel(arf_id_t id, rat_entry_t e, reg_data_t arf_data,
                                           logic retire, rob_id_t retire_rob_id,
                                           reg_data_t retire_data);
        logic byp;
        byp = e.valid && retire && (e.rob_id == retire_rob_id);
        lookup_sel = '0;
        if (id != '0) begin
            lookup_sel.data    = byp ? retire_data : arf_data;
            lookup_sel.renamed = e.valid && !byp;
            lookup_sel.rob_id  = lookup_sel.renamed ? e.rob_id : '0;
        end
    endfunction

endpackage

// File: rtl/arf_rename_if.sv
// arf_rename_if: retire, dispatch and source-lookup bus between pipeline and ARF/RAT
interface arf_rename_if;
    import arf_rename_pkg::*;

    logic      retire;
    rob_id_t   retire_rob_id;
    arf_id_t   retire_arf_id;
    reg_data_t retire_reg_data;
    logic      dispatch_fire;
    logic      dispatch_dst_valid;
    arf_id_t   dispatch_dst_arf_id;
    rob_id_t   dispatch_rob_id;
    logic      flush;
    arf_id_t   src1_arf_id;
    arf_id_t   src2_arf_id;
    logic      src1_renamed;
    logic      src2_renamed;
    rob_id_t   src1_rob_id;
    rob_id_t   src2_rob_id;
    reg_data_t src1_reg_data;
    reg_data_t src2_reg_data;

    modport master (
        output retire, retire_rob_id, retire_arf_id, retire_reg_data,
               dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
               flush, src1_arf_id, src2_arf_id,
        input  src1_renamed, src2_renamed, src1_rob_id, src2_rob_id,
               src1_reg_data, src2_reg_data
    );

    modport slave (
        input  retire, retire_rob_id, retire_arf_id, retire_reg_data,
               dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
               flush, src1_arf_id, src2_arf_id,
        output src1_renamed, src2_renamed, src1_rob_id, src2_rob_id,
               src1_reg_data, src2_reg_data
    );

endinterface

// File: rtl/arf_rename_rat_entry.sv
// rat_entry: one rename-table slot {valid, rob_id} for a single architectural register
module rat_entry
    import arf_rename_pkg::*;
(
    input  logic       clk,
    input  logic       rst_aL,
    input  logic       flush,
    input  logic       rename,
    input  rob_id_t    rename_rob_id,
    input  logic       retire_hit,
    input  rob_id_t    retire_rob_id,
    output rat_entry_t entry
);

    rat_entry_t entry_q, entry_d;

    // Priority flush > rename > retire-clear > hold; retire only clears the
    // mapping if the retiring instruction is still the youngest producer.
    always_comb begin
        entry_d = entry_q;
        if (flush)
            entry_d.valid = 1'b0;
        else if (rename)
            entry_d = '{valid: 1'b1, rob_id: rename_rob_id};
        else if (retire_hit && entry_q.valid && entry_q.rob_id == retire_rob_id)
            entry_d.valid = 1'b0;
    end

    // Slot state register
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL)
            entry_q <= '0;
        else
            entry_q <= entry_d;
    end

    assign entry = entry_q;

endmodule

// File: rtl/arf_rename.sv
// arf_rename: architectural register file plus rename table with retire bypass
module arf_rename
    import arf_rename_pkg::*;
#(
    parameter int N_ARF = 32
) (
    input logic         clk,
    input logic         rst_aL,
    arf_rename_if.slave bus
);

    rat_entry_t rat [N_ARF];
    reg_data_t  arf [N_ARF];
    logic       rename_ok;
    lookup_t    lk1, lk2;

    assign rename_ok = bus.dispatch_fire && bus.dispatch_dst_valid && !bus.flush;
    assign rat[0]    = '0;
    assign arf[0]    = '0;

    for (genvar i = 1; i < N_ARF; i++) begin : g_reg
        reg_data_t arf_q, arf_d;
        logic      wr;
        assign wr = bus.retire && bus.retire_arf_id == arf_id_t'(i);
        // Committed value is written on every retire to this register
        always_comb arf_d = wr ? bus.retire_reg_data : arf_q;
        // Data register
        always_ff @(posedge clk or negedge rst_aL) begin
            if (!rst_aL)
                arf_q <= '0;
            else
                arf_q <= arf_d;
        end
        assign arf[i] = arf_q;
        rat_entry u_rat (
            .clk          (clk),
            .rst_aL       (rst_aL),
            .flush        (bus.flush),
            .rename       (rename_ok && bus.dispatch_dst_arf_id == arf_id_t'(i)),
            .rename_rob_id(bus.dispatch_rob_id),
            .retire_hit   (wr),
            .retire_rob_id(bus.retire_rob_id),
            .entry        (rat[i])
        );
    end

    assign lk1 = lookup_sel(bus.src1_arf_id, rat[bus.src1_arf_id], arf[bus.src1_arf_id],
                            bus.retire, bus.retire_rob_id, bus.retire_reg_data);
    assign lk2 = lookup_sel(bus.src2_arf_id, rat[bus.src2_arf_id], arf[bus.src2_arf_id],
                            bus.retire, bus.retire_rob_id, bus.retire_reg_data);

    assign bus.src1_renamed  = lk1.renamed;
    assign bus.src1_rob_id   = lk1.rob_id;
    assign bus.src1_reg_data = lk1.data;
    assign bus.src2_renamed  = lk2.renamed;
    assign bus.src2_rob_id   = lk2.rob_id;
    assign bus.src2_reg_data = lk2.data;

endmodule

// File: tb/tb_arf_rename.sv
// tb_arf_rename: table-driven scoreboard bench for arf_rename
module tb_arf_rename;
    import arf_rename_pkg::*;

    typedef struct {
        logic      ret;
        rob_id_t   rrob;
        arf_id_t   rarf;
        reg_data_t rdat;
        logic      disp;
        logic      dval;
        arf_id_t   darf;
        rob_id_t   drob;
        logic      fl;
        arf_id_t   s1;
        logic      e1r;
        rob_id_t   e1rob;
        reg_data_t e1d;
        arf_id_t   s2;
        logic      e2r;
        rob_id_t   e2rob;
        reg_data_t e2d;
    } vec_t;

    typedef struct {
        string     nm;
        logic      e1r;
        rob_id_t   e1rob;
        reg_data_t e1d;
        logic      e2r;
        rob_id_t   e2rob;
        reg_data_t e2d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_aL = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    arf_rename_if bus ();

    arf_rename #(.N_ARF(32)) dut (
        .clk   (clk),
        .rst_aL(rst_aL),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t v(int ret, int rrob, int rarf, int rdat, int disp, int dval,
                               int darf, int drob, int fl, int s1, int e1r, int e1rob,
                               int e1d, int s2, int e2r, int e2rob, int e2d);
        v.ret   = ret[0];
        v.rrob  = rob_id_t'(rrob);
        v.rarf  = arf_id_t'(rarf);
        v.rdat  = reg_data_t'(rdat);
        v.disp  = disp[0];
        v.dval  = dval[0];
        v.darf  = arf_id_t'(darf);
        v.drob  = rob_id_t'(drob);
        v.fl    = fl[0];
        v.s1    = arf_id_t'(s1);
        v.e1r   = e1r[0];
        v.e1rob = rob_id_t'(e1rob);
        v.e1d   = reg_data_t'(e1d);
        v.s2    = arf_id_t'(s2);
        v.e2r   = e2r[0];
        v.e2rob = rob_id_t'(e2rob);
        v.e2d   = reg_data_t'(e2d);
    endfunction

    task automatic drive(input vec_t x);
        bus.retire              = x.ret;
        bus.retire_rob_id       = x.rrob;
        bus.retire_arf_id       = x.rarf;
        bus.retire_reg_data     = x.rdat;
        bus.dispatch_fire       = x.disp;
        bus.dispatch_dst_valid  = x.dval;
        bus.dispatch_dst_arf_id = x.darf;
        bus.dispatch_rob_id     = x.drob;
        bus.flush               = x.fl;
        bus.src1_arf_id         = x.s1;
        bus.src2_arf_id         = x.s2;
    endtask

    // rob_id is only meaningful when renamed, data only when not renamed
    task automatic chk(input string nm, input logic er, input rob_id_t erob, input reg_data_t ed,
                       input logic ar, input rob_id_t arob, input reg_data_t ad);
        n_total++;
        if ((ar == er) && (!er || arob == erob) && (er || ad == ed))
            n_pass++;
        else
            $display("FAIL %s: got renamed=%0b rob=%0d data=%h, want renamed=%0b rob=%0d data=%h",
                     nm, ar, arob, ad, er, erob, ed);
    endtask

    task automatic chk_both(input exp_t e);
        chk({e.nm, "_s1"}, e.e1r, e.e1rob, e.e1d, bus.src1_renamed, bus.src1_rob_id, bus.src1_reg_data);
        chk({e.nm, "_s2"}, e.e2r, e.e2rob, e.e2d, bus.src2_renamed, bus.src2_rob_id, bus.src2_reg_data);
    endtask

    task automatic apply(input string nm, input vec_t x);
        exp_t e;
        @(negedge clk);
        drive(x);
        exp_q.push_back('{nm, x.e1r, x.e1rob, x.e1d, x.e2r, x.e2rob, x.e2d});
        #2;
        e = exp_q.pop_front();
        chk_both(e);
    endtask

    initial begin
        drive(v(0,0,0,0, 0,0,0,0, 0, 5,0,0,0, 0,0,0,0));
        repeat (2) @(negedge clk);
        #1;
        chk_both('{"reset", 1'b0, '0, '0, 1'b0, '0, '0});
        rst_aL = 1'b1;

        //        ret rrob rarf rdat     disp dval darf drob fl  s1 r rob d      s2 r rob d
        vecs.push_back(v(1, 0, 0, 'hDEAD, 0,0, 0, 0,  0,  0,0,0,0,       5,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 3, 7,  0,  0,0,0,0,       3,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      0,0, 0, 0,  0,  3,1,7,0,       0,0,0,0));
        vecs.push_back(v(1, 7, 3, 'h1234, 0,0, 0, 0,  0,  3,0,0,'h1234,  5,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      0,0, 0, 0,  0,  3,0,0,'h1234,  0,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 3, 7,  0,  3,0,0,'h1234,  0,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 3, 9,  0,  3,1,7,0,       0,0,0,0));
        vecs.push_back(v(1, 7, 3, 'h11,   0,0, 0, 0,  0,  3,1,9,0,       3,1,9,0));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 6, 4,  0,  3,1,9,0,       6,0,0,0));
        vecs.push_back(v(1, 4, 6, 'h66,   1,1, 6, 12, 0,  6,0,0,'h66,    3,1,9,0));
        vecs.push_back(v(1, 9, 3, 'h99,   0,0, 0, 0,  0,  6,1,12,0,      3,0,0,'h99));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 1, 1,  0,  1,0,0,0,       3,0,0,'h99));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 2, 2,  0,  1,1,1,0,       2,0,0,0));
        vecs.push_back(v(1, 1, 1, 'h55,   1,1, 8, 3,  1,  1,0,0,'h55,    2,1,2,0));
        vecs.push_back(v(0, 0, 0, 0,      0,0, 0, 0,  0,  1,0,0,'h55,    8,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      1,0, 4, 6,  0,  2,0,0,0,       6,0,0,'h66));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 10,5,  0,  4,0,0,0,       12,0,0,0));
        vecs.push_back(v(0, 0, 0, 0,      1,1, 0, 3,  0,  4,0,0,0,       10,1,5,0));
        vecs.push_back(v(0, 0, 0, 0,      0,0, 0, 0,  0,  0,0,0,0,       10,1,5,0));

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        apply("pre_rst", v(0,0,0,0, 0,0,0,0, 0, 10,1,5,0, 3,0,0,'h99));
        rst_aL = 1'b0;
        #1;
        chk_both('{"async_rst", 1'b0, '0, '0, 1'b0, '0, '0});
        @(negedge clk);
        rst_aL = 1'b1;
        apply("post_rst", v(0,0,0,0, 0,0,0,0, 0, 10,0,0,0, 6,0,0,0));

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
